// File: rtl/vjtag_debug_bridge.sv
// vjtag_debug_bridge: virtual JTAG TAP-side responder. It decodes the
// instruction register, runs a 32-bit data shift register with a
// length that depends on the instruction, and turns WRITE/READ
// update-DR events into byte requests on a debug memory port.
// Everything runs in the tck domain, which drives `clock`.
module vjtag_debug_bridge #(
  parameter logic [31:0] IDCODE = 32'h4E45_5301
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tdi,
  output logic        tdo,
  input  logic [23:0] ir_in,
  output logic [23:0] ir_out,
  input  logic        virtual_state_cdr,
  input  logic        virtual_state_sdr,
  input  logic        virtual_state_e1dr,
  input  logic        virtual_state_pdr,
  input  logic        virtual_state_e2dr,
  input  logic        virtual_state_udr,
  input  logic        virtual_state_cir,
  input  logic        virtual_state_uir,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [15:0] mem_req_addr,
  output logic [7:0]  mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [7:0]  mem_resp_rdata
);

  typedef enum logic [2:0] {
    INS_BYPASS,
    INS_IDCODE,
    INS_SET_ADDR,
    INS_WRITE,
    INS_READ,
    INS_STATUS
  } instr_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } req_state_e;

  instr_e     instr;
  req_state_e state_q;
  req_state_e state_next;

  logic [31:0] sr;
  logic [31:0] sr_capture;
  logic [31:0] sr_shift;
  logic [15:0] addr;
  logic [7:0]  rdata_q;
  logic        rd_valid;
  logic        overrun;
  logic        busy;
  logic        is_mem_op;
  logic        issue;

  // The exit/pause states and IR-side strobes carry no action here; the
  // upper IR bits are reserved. Folding them keeps them visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{ir_in[23:8], virtual_state_e1dr, virtual_state_pdr,
                           virtual_state_e2dr, virtual_state_cir, virtual_state_uir};

  assign busy      = (state_q != ST_IDLE);
  assign is_mem_op = (instr == INS_WRITE) || (instr == INS_READ);
  assign issue     = virtual_state_udr && is_mem_op && !busy;

  // Instruction decode straight from ir_in; unknown codes act as BYPASS.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    instr = INS_BYPASS;
    case (ir_in[7:0])
      8'h01:   instr = INS_IDCODE;
      8'h02:   instr = INS_SET_ADDR;
      8'h03:   instr = INS_WRITE;
      8'h04:   instr = INS_READ;
      8'h05:   instr = INS_STATUS;
      default: instr = INS_BYPASS;
    endcase
  end

  // Capture value and LSB-first shift value; tdi enters at bit L-1.
  always_comb begin
    sr_capture = 32'h0;
    sr_shift   = {1'b0, sr[31:1]};
    case (instr)
      INS_IDCODE: begin
        sr_capture   = IDCODE;
        sr_shift[31] = tdi;
      end
      INS_SET_ADDR: begin
        sr_capture   = {16'h0, addr};
        sr_shift[15] = tdi;
      end
      INS_WRITE: begin
        sr_capture  = 32'h0;
        sr_shift[7] = tdi;
      end
      INS_READ: begin
        sr_capture  = {24'h0, rdata_q};
        sr_shift[7] = tdi;
      end
      INS_STATUS: begin
        sr_capture  = {24'h0, 5'b0, overrun, rd_valid, busy};
        sr_shift[7] = tdi;
      end
      default: begin
        sr_capture  = 32'h0;
        sr_shift[0] = tdi;
      end
    endcase
  end

  // Shift register, tdo, status register and the address/data datapath.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the shift register is reset along with the status state even
      // though its contents are reloaded on every capture; this keeps tdo
      // deterministic straight out of reset.
      sr            <= 32'h0;
      tdo           <= 1'b0;
      ir_out        <= 24'h0;
      addr          <= 16'h0;
      rdata_q       <= 8'h0;
      rd_valid      <= 1'b0;
      overrun       <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= 16'h0;
      mem_req_wdata <= 8'h0;
    end else begin
      tdo    <= sr[0];
      ir_out <= {16'h0, 5'b0, overrun, rd_valid, busy};

      if (virtual_state_cdr) begin
        sr <= sr_capture;
      end else if (virtual_state_sdr) begin
        sr <= sr_shift;
      end

      if (virtual_state_udr) begin
        case (instr)
          INS_SET_ADDR: addr <= sr[15:0];
          INS_STATUS:   if (sr[2]) overrun <= 1'b0;
          INS_WRITE, INS_READ: begin
            if (busy) begin
              overrun <= 1'b1;
            end else begin
              mem_req_write <= (instr == INS_WRITE);
              mem_req_addr  <= addr;
              addr          <= addr + 16'd1;
              if (instr == INS_WRITE) mem_req_wdata <= sr[7:0];
              else                    rd_valid      <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Responses only count while a read is outstanding.
      if (state_q == ST_WAIT && mem_resp_valid) begin
        rdata_q  <= mem_resp_rdata;
        rd_valid <= 1'b1;
      end
    end
  end

  // Request FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  // Request FSM next state; valid is asserted for the whole REQ state.
  always_comb begin
    state_next    = state_q;
    mem_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (issue) state_next = ST_REQ;
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = mem_req_write ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: if (mem_resp_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vjtag_debug_bridge.sv
// Self-checking bench for vjtag_debug_bridge. A reference model of the
// bridge (address pointer, last read byte, status flags, byte memory) is
// kept at transaction level; directed scenarios run first, then a
// randomized mix of scans.
module tb_vjtag_debug_bridge;

  localparam logic [7:0] I_BYPASS = 8'h00;
  localparam logic [7:0] I_IDCODE = 8'h01;
  localparam logic [7:0] I_SETADR = 8'h02;
  localparam logic [7:0] I_WRITE  = 8'h03;
  localparam logic [7:0] I_READ   = 8'h04;
  localparam logic [7:0] I_STATUS = 8'h05;

  logic        clock = 1'b0;
  logic        reset;
  logic        tdi;
  logic        tdo;
  logic [23:0] ir_in;
  logic [23:0] ir_out;
  logic        cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [15:0] mem_req_addr;
  logic [7:0]  mem_req_wdata;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [15:0] m_addr;
  logic [7:0]  m_rdata;
  logic        m_rd_valid;
  logic        m_overrun;
  logic [7:0]  m_mem [logic [15:0]];
  logic        seen_valid;

  vjtag_debug_bridge dut (
    .clock              (clock),
    .reset              (reset),
    .tdi                (tdi),
    .tdo                (tdo),
    .ir_in              (ir_in),
    .ir_out             (ir_out),
    .virtual_state_cdr  (cdr),
    .virtual_state_sdr  (sdr),
    .virtual_state_e1dr (e1dr),
    .virtual_state_pdr  (pdr),
    .virtual_state_e2dr (e2dr),
    .virtual_state_udr  (udr),
    .virtual_state_cir  (cir),
    .virtual_state_uir  (uir),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_write      (mem_req_write),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wdata      (mem_req_wdata),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_rdata     (mem_resp_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic dr_capture(input logic [7:0] ins);
    ir_in = {16'hABCD, ins};
    cdr   = 1'b1;
    tick();
    cdr   = 1'b0;
  endtask

  task automatic dr_shift(input int len, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    sdr  = 1'b1;
    for (int k = 0; k < len; k++) begin
      tdi = din[k];
      tick();
      dout[k] = tdo;
      seen_valid = seen_valid | mem_req_valid;
    end
    sdr = 1'b0;
  endtask

  task automatic dr_update();
    e1dr = 1'b1;
    tick();
    e1dr = 1'b0;
    udr  = 1'b1;
    tick();
    udr  = 1'b0;
  endtask

  task automatic scan_dr(input logic [7:0] ins, input logic [31:0] din, input int len,
                         output logic [31:0] dout);
    seen_valid = 1'b0;
    dr_capture(ins);
    dr_shift(len, din, dout);
    dr_update();
  endtask

  task automatic check_ir_out(input string tag);
    tick();
    check(tag, {8'h0, ir_out}, {8'h0, 16'h0, 5'b0, m_overrun, m_rd_valid, 1'b0});
  endtask

  task automatic op_set_addr(input logic [15:0] a);
    logic [31:0] dout;
    scan_dr(I_SETADR, {16'h0, a}, 16, dout);
    check("setaddr_capture", {16'h0, dout[15:0]}, {16'h0, m_addr});
    m_addr = a;
  endtask

  task automatic op_write(input logic [7:0] d);
    logic [31:0] dout;
    mem_req_ready = 1'b1;
    scan_dr(I_WRITE, {24'h0, d}, 8, dout);
    check("write_capture", {24'h0, dout[7:0]}, 32'h0);
    check("write_req", {7'h0, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata},
          {7'h0, 1'b1, 1'b1, m_addr, d});
    tick();
    check("write_done", {31'h0, mem_req_valid}, 32'h0);
    m_mem[m_addr] = d;
    m_addr = m_addr + 16'd1;
  endtask

  task automatic read_issue_checks();
    check("read_req", {7'h0, mem_req_valid, mem_req_write, mem_req_addr, 8'h0},
          {7'h0, 1'b1, 1'b0, m_addr, 8'h0});
    m_rd_valid = 1'b0;
    tick();
    check("read_accepted", {31'h0, mem_req_valid}, 32'h0);
  endtask

  task automatic read_respond(input int delay);
    logic [7:0] data;
    repeat (delay) tick();
    if (m_mem.exists(m_addr)) data = m_mem[m_addr];
    else begin
      data = 8'($urandom);
      m_mem[m_addr] = data;
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = data;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 8'h0;
    m_rdata    = data;
    m_rd_valid = 1'b1;
    m_addr     = m_addr + 16'd1;
  endtask

  task automatic op_read(input int delay);
    logic [31:0] dout;
    mem_req_ready = 1'b1;
    scan_dr(I_READ, $urandom, 8, dout);
    check("read_shift_out", {24'h0, dout[7:0]}, {24'h0, m_rdata});
    read_issue_checks();
    read_respond(delay);
  endtask

  task automatic op_status(input logic [7:0] din, input logic busy);
    logic [31:0] dout;
    scan_dr(I_STATUS, {24'h0, din}, 8, dout);
    check("status_capture", {24'h0, dout[7:0]}, {24'h0, 5'b0, m_overrun, m_rd_valid, busy});
    if (din[2]) m_overrun = 1'b0;
  endtask

  task automatic op_bypass(input logic [7:0] ins, input logic [3:0] din);
    logic [31:0] dout;
    scan_dr(ins, {28'h0, din}, 4, dout);
    // A one-bit register: first bit out is the captured 0, then tdi delayed by one.
    check("bypass_delay", {28'h0, dout[3:0]}, {28'h0, din[2:0], 1'b0});
  endtask

  initial begin
    logic [31:0] dout;
    logic [7:0]  old_rdata;
    logic [7:0]  newd;
    reset = 1'b1; tdi = 1'b0; ir_in = 24'h0;
    cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 8'h0;
    m_addr = 16'h0; m_rdata = 8'h0; m_rd_valid = 1'b0; m_overrun = 1'b0;
    seen_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state.
    check("reset_outputs", {6'h0, tdo, mem_req_valid, mem_req_write, ir_out[22:0]}, 32'h0);
    check("reset_req_fields", {8'h0, mem_req_addr, mem_req_wdata}, 32'h0);

    // IDCODE scan with no memory traffic.
    scan_dr(I_IDCODE, 32'h0, 32, dout);
    check("idcode", dout, 32'h4E45_5301);
    check("idcode_no_req", {31'h0, seen_valid}, 32'h0);

    // BYPASS and an undecoded instruction.
    op_bypass(I_BYPASS, 4'b1011);
    op_bypass(8'hC7, 4'b0110);

    // SET_ADDR 0x2000, then two writes.
    op_set_addr(16'h2000);
    op_write(8'hA5);
    op_write(8'h5A);
    op_set_addr(16'h0300);   // capture shows 0x2002

    // Read 0x0300 with a 3-cycle response, then a pipelined second read.
    m_mem[16'h0300] = 8'h3C;
    op_read(3);
    op_status(8'h00, 1'b0);
    op_read(1);
    check("pipelined_read_value", {24'h0, m_rdata}, {24'h0, m_mem[16'h0301]});
    op_status(8'h00, 1'b0);
    check_ir_out("ir_out_after_reads");

    // Overrun: ready low, two writes; the second is dropped.
    mem_req_ready = 1'b0;
    scan_dr(I_WRITE, 32'h11, 8, dout);
    check("ovr_first_req", {7'h0, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata},
          {7'h0, 1'b1, 1'b1, m_addr, 8'h11});
    scan_dr(I_WRITE, 32'h22, 8, dout);
    m_overrun = 1'b1;
    check("ovr_req_stable", {7'h0, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata},
          {7'h0, 1'b1, 1'b1, m_addr, 8'h11});
    tick();
    check("ovr_ir_out_bit2", {31'h0, ir_out[2]}, 32'h1);
    op_status(8'h00, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    check("ovr_accept_drop", {31'h0, mem_req_valid}, 32'h0);
    m_mem[m_addr] = 8'h11;
    m_addr = m_addr + 16'd1;
    op_set_addr(16'hFFFF);   // capture proves a single increment
    op_status(8'h04, 1'b0);  // clears overrun
    check_ir_out("ovr_cleared");

    // Address wrap.
    op_write(8'hE1);
    check("wrap_addr", {16'h0, m_addr}, 32'h0);
    op_write(8'hE2);

    // Response arriving together with the next READ capture.
    op_set_addr(16'h0040);
    mem_req_ready = 1'b1;
    scan_dr(I_READ, 32'h0, 8, dout);
    check("sim_first_out", {24'h0, dout[7:0]}, {24'h0, m_rdata});
    read_issue_checks();
    old_rdata = m_rdata;
    newd = 8'($urandom);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = newd;
    dr_capture(I_READ);
    mem_resp_valid = 1'b0;
    m_mem[m_addr] = newd;
    m_rdata = newd; m_rd_valid = 1'b1; m_addr = m_addr + 16'd1;
    dr_shift(8, 32'h0, dout);
    check("sim_old_captured", {24'h0, dout[7:0]}, {24'h0, old_rdata});
    dr_update();
    read_issue_checks();
    read_respond(0);
    op_read(2);

    // Reset while waiting for a read response.
    mem_req_ready = 1'b1;
    scan_dr(I_READ, 32'h0, 8, dout);
    check("rst_pre_read", {24'h0, dout[7:0]}, {24'h0, m_rdata});
    read_issue_checks();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_addr = 16'h0; m_rdata = 8'h0; m_rd_valid = 1'b0; m_overrun = 1'b0;
    check("rst_wait_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_wait_ir_out", {8'h0, ir_out}, 32'h0);
    tick();
    check("rst_wait_busy", {8'h0, ir_out}, 32'h0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 8'h99;
    tick();
    mem_resp_valid = 1'b0;
    op_status(8'h00, 1'b0);
    op_read(1);              // shifts out rdata_q, which must still be 0

    // Randomized mix against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: op_set_addr(($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                   : 16'h0100 + 16'($urandom_range(0, 7)));
        1: op_write(8'($urandom));
        2: op_read(int'($urandom_range(0, 3)));
        3: op_status(8'($urandom), 1'b0);
        default: op_bypass(8'($urandom_range(6, 255)), 4'($urandom));
      endcase
      check_ir_out("rand_ir_out");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
